// File: rtl/spi_master_fifo_wb.sv
// WISHBONE SPI master with parametrised TX/RX FIFOs and SS framing.
// Optional loopback (CTRL[1]) is built only with `define SPI_LOOPBACK_EN.
module spi_master_fifo_wb #(
  parameter int SS_WIDTH   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic [2:0]          adr_i,
  input  logic                we_i,
  input  logic [7:0]          dat_i,
  output logic [7:0]          dat_o,
  output logic                ack_o,
  output logic                inta_o,
  output logic                sck_o,
  output logic [SS_WIDTH-1:0] ss_o,
  output logic                mosi_o,
  input  logic                miso_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] P1 = 1;
  localparam logic [DIV_W-1:0] C1 = 1;

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t           state;
  logic [7:0]       ctrl, divl, ss_r, icnt, fcnt;
  logic             if_f, wcol, rovf;
  logic [DIV_W-1:0] div_v, cnt;
  logic [7:0]       divh_rd, rdata;
  logic [3:0]       hp;
  logic [7:0]       sreg, rreg, rx_next, rx_byte, tx_dout;
  logic [7:0]       tx_mem [FIFO_DEPTH];
  logic [7:0]       rx_mem [FIFO_DEPTH];
  logic [AW:0]      tx_wp, tx_rp, rx_wp, rx_rp;

  logic req, wr, rd, stat_wr, if_clr, abort;
  logic ie, en, lsbf, ass, cpol, cpha, loop, rin;
  logic tx_empty, tx_full, rx_empty, rx_full, busy;
  logic tick, fend, tx_pop, tx_push, rx_push, rx_pop;
  logic sample, shift_ev, hit;
  logic [7:0] fbase;

`ifdef SPI_LOOPBACK_EN
  localparam logic [7:0] CMASK = 8'hFE;
  assign loop = ctrl[1];
`else
  localparam logic [7:0] CMASK = 8'hFC;
  assign loop = 1'b0;
`endif

  assign ie   = ctrl[7];
  assign en   = ctrl[6];
  assign lsbf = ctrl[5];
  assign ass  = ctrl[4];
  assign cpol = ctrl[3];
  assign cpha = ctrl[2];

  assign req     = cyc_i & stb_i & ~ack_o;
  assign wr      = req & we_i;
  assign rd      = req & ~we_i;
  assign stat_wr = wr && adr_i == 3'd1;
  assign if_clr  = stat_wr && dat_i[7];
  assign abort   = wr && adr_i == 3'd0 && en && !dat_i[6];

  assign tx_empty = tx_wp == tx_rp;
  assign tx_full  = (tx_wp[AW] != tx_rp[AW]) &&
                    (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) &&
                    (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign busy     = state != IDLE;
  assign tx_dout  = tx_mem[tx_rp[AW-1:0]];

  assign tick     = busy && cnt == div_v;
  assign fend     = state == SHIFT && tick && hp == 4'd15 && !abort;
  assign tx_pop   = !abort && !tx_empty &&
                    ((state == IDLE && en) || fend);
  assign tx_push  = wr && adr_i == 3'd2 && !tx_full;
  assign rx_push  = fend && !rx_full;
  assign rx_pop   = rd && adr_i == 3'd2 && !rx_empty;
  assign sample   = state == SHIFT && tick && (hp[0] == cpha);
  assign shift_ev = state == SHIFT && tick && (hp[0] != cpha) &&
                    hp != 4'd15;

  assign rin     = loop ? mosi_o : miso_i;
  assign rx_next = lsbf ? {rin, rreg[7:1]} : {rreg[6:0], rin};
  assign rx_byte = sample ? rx_next : rreg;
  assign fbase   = if_clr ? 8'd0 : fcnt;
  assign hit     = fbase == icnt;
  assign inta_o  = if_f & ie;

  function automatic logic obit(input logic [7:0] d, input logic l);
    return l ? d[0] : d[7];
  endfunction

  function automatic logic [7:0] shf(input logic [7:0] d, input logic l);
    return l ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
  endfunction

  if (DIV_W > 8) begin : g_divh
    logic [DIV_W-9:0] divh;
    // upper divider bits
    always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) divh <= '0;
      else if (wr && adr_i == 3'd6) divh <= dat_i[DIV_W-9:0];
    assign div_v   = {divh, divl};
    assign divh_rd = 8'(divh);
  end else begin : g_nodivh
    assign div_v   = divl;
    assign divh_rd = 8'h00;
  end

  // select lines: manual mask, framed by the FSM when ASS is set
  always_comb begin
    ss_o = ~SS_WIDTH'(ss_r);
    if (ass && state == IDLE) ss_o = '1;
    if (loop) ss_o = '1;
  end

  // register read mux
  always_comb begin
    rdata = 8'h00;
    case (adr_i)
      3'd0: rdata = ctrl;
      3'd1: rdata = {if_f, wcol, rovf, busy,
                     tx_full, tx_empty, rx_full, rx_empty};
      3'd2: rdata = rx_empty ? 8'h00 : rx_mem[rx_rp[AW-1:0]];
      3'd3: rdata = divl;
      3'd4: rdata = ss_r;
      3'd5: rdata = icnt;
      3'd6: rdata = divh_rd;
      default: rdata = 8'h00;
    endcase
  end

  // bus handshake and control registers
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      ack_o <= 1'b0;
      dat_o <= 8'h00;
      ctrl  <= 8'h00;
      divl  <= 8'h00;
      ss_r  <= 8'h00;
      icnt  <= 8'h00;
    end else begin
      ack_o <= req;
      if (rd) dat_o <= rdata;
      if (wr) begin
        case (adr_i)
          3'd0: ctrl <= dat_i & CMASK;
          3'd3: divl <= dat_i;
          3'd4: ss_r <= dat_i;
          3'd5: icnt <= dat_i;
          default: ;
        endcase
      end
    end

  // sticky status flags and frame counter
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      if_f <= 1'b0;
      wcol <= 1'b0;
      rovf <= 1'b0;
      fcnt <= 8'h00;
    end else begin
      if (wr && adr_i == 3'd2 && tx_full) wcol <= 1'b1;
      else if (stat_wr && dat_i[6]) wcol <= 1'b0;
      if (fend && rx_full) rovf <= 1'b1;
      else if (stat_wr && dat_i[5]) rovf <= 1'b0;
      if (fend && hit) if_f <= 1'b1;
      else if (if_clr) if_f <= 1'b0;
      if (abort) fcnt <= 8'h00;
      else fcnt <= fend ? fbase + 8'd1 : fbase;
    end

  // FIFO pointers; disabling EN flushes both
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else if (abort) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + P1;
      if (tx_pop)  tx_rp <= tx_rp + P1;
      if (rx_push) rx_wp <= rx_wp + P1;
      if (rx_pop)  rx_rp <= rx_rp + P1;
    end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= dat_i;
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_byte;
  end

  // transfer FSM: framing, sck generation, shift and sample
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      hp     <= 4'd0;
      sck_o  <= 1'b0;
      mosi_o <= 1'b0;
      sreg   <= 8'h00;
      rreg   <= 8'h00;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
      hp    <= 4'd0;
      sck_o <= dat_i[3];
    end else begin
      unique case (state)
        IDLE: begin
          sck_o <= cpol;
          cnt   <= '0;
          hp    <= 4'd0;
          if (tx_pop) begin
            sreg <= cpha ? tx_dout : shf(tx_dout, lsbf);
            if (!cpha) mosi_o <= obit(tx_dout, lsbf);
            state <= ass ? LEAD : SHIFT;
          end
        end
        LEAD: begin
          if (tick) begin
            cnt   <= '0;
            state <= SHIFT;
          end else cnt <= cnt + C1;
        end
        SHIFT: begin
          if (tick) begin
            cnt   <= '0;
            hp    <= hp + 4'd1;
            sck_o <= ~sck_o;
            if (sample) rreg <= rx_next;
            if (shift_ev) begin
              mosi_o <= obit(sreg, lsbf);
              sreg   <= shf(sreg, lsbf);
            end
            if (hp == 4'd15) begin
              if (tx_pop) begin
                sreg <= cpha ? tx_dout : shf(tx_dout, lsbf);
                if (!cpha) mosi_o <= obit(tx_dout, lsbf);
              end else state <= ass ? TRAIL : IDLE;
            end
          end else cnt <= cnt + C1;
        end
        TRAIL: begin
          if (tick) begin
            cnt   <= '0;
            state <= IDLE;
          end else cnt <= cnt + C1;
        end
      endcase
    end

endmodule

// File: tb/tb_spi_master_fifo_wb.sv
// Scoreboard bench for spi_master_fifo_wb.
// Bus tasks, an SPI line monitor and per-feature scenarios.
module tb_spi_master_fifo_wb;
  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [2:0] adr = 3'd0;
  logic [7:0] dat_w = 8'h00;
  logic [7:0] dat_o;
  logic       ack, inta, sck, mosi, miso;
  logic [7:0] ss;
  logic       miso_loop = 1'b1;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  bit         mon_on = 1'b0;
  logic       m_cpol, m_cpha, m_lsbf;
  logic [7:0] m_byte;
  int m_bits, m_frames, m_edges, ss_low, ss_rise;
  int iv_min, iv_max, last_edge, cyc_n, inta_frames;
  logic sck_p, ss0_p, inta_p;

  assign miso = miso_loop ? mosi : 1'b0;

  spi_master_fifo_wb dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .cyc_i (cyc),
    .stb_i (stb),
    .adr_i (adr),
    .we_i  (we),
    .dat_i (dat_w),
    .dat_o (dat_o),
    .ack_o (ack),
    .inta_o(inta),
    .sck_o (sck),
    .ss_o  (ss),
    .mosi_o(mosi),
    .miso_i(miso)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // line monitor: rebuilds MOSI frames and checks them against tx_q
  always @(posedge clk) begin
    logic [7:0] exp;
    int iv;
    #2;
    cyc_n++;
    if (mon_on) begin
      if (ss[0] == 1'b0) ss_low++;
      if (ss0_p == 1'b0 && ss[0] == 1'b1) ss_rise++;
      if (inta && !inta_p && inta_frames < 0) inta_frames = m_frames;
      if (sck != sck_p) begin
        m_edges++;
        if (last_edge >= 0) begin
          iv = cyc_n - last_edge;
          if (iv < iv_min) iv_min = iv;
          if (iv > iv_max) iv_max = iv;
        end
        last_edge = cyc_n;
        if ((sck != m_cpol) != m_cpha) begin
          m_byte = m_lsbf ? {mosi, m_byte[7:1]} : {m_byte[6:0], mosi};
          m_bits++;
          if (m_bits == 8) begin
            m_bits = 0;
            m_frames++;
            vectors++;
            if (tx_q.size() == 0) begin
              errors++;
              $display("FAIL mosi_frame: got %02h, none expected", m_byte);
            end else begin
              exp = tx_q.pop_front();
              if (m_byte !== exp) begin
                errors++;
                $display("FAIL mosi_frame: got %02h want %02h", m_byte, exp);
              end
            end
          end
        end
      end
    end
    sck_p  = sck;
    ss0_p  = ss[0];
    inta_p = inta;
  end

  task automatic mon_start(input logic cp, input logic ph, input logic lf);
    m_cpol = cp;
    m_cpha = ph;
    m_lsbf = lf;
    m_bits = 0;
    m_byte = 8'h00;
    m_frames = 0;
    m_edges = 0;
    ss_low = 0;
    ss_rise = 0;
    iv_min = 1000000;
    iv_max = 0;
    last_edge = -1;
    inta_frames = -1;
    sck_p = sck;
    ss0_p = ss[0];
    inta_p = inta;
    mon_on = 1'b1;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      vectors++; errors++;
      $display("FAIL wb_ack: no ack on write adr=%0d", a);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    if (!ack) begin
      vectors++; errors++;
      $display("FAIL wb_ack: no ack on read adr=%0d", a);
    end
    d = dat_o;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_idle();
    logic [7:0] s;
    int n;
    n = 0;
    do begin
      wb_read(3'd1, s);
      n++;
    end while ((s[4] || !s[2]) && n < 500);
    if (s[4] || !s[2]) begin
      vectors++; errors++;
      $display("FAIL wait_idle: stat %02h still busy", s);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (ack !== 1'b0 || dat_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: ack=%b dat=%02h want 0/00", ack, dat_o);
    end
    vectors++;
    if (ss !== 8'hFF || sck !== 1'b0 || mosi !== 1'b0 || inta !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: ss=%02h sck=%b mosi=%b inta=%b", ss, sck, mosi, inta);
    end
    @(negedge clk);
    rst_i = 1'b1;
    wb_read(3'd1, v);
    vectors++;
    if (v !== 8'h05) begin
      errors++;
      $display("FAIL reset_stat: got %02h want 05", v);
    end
    wb_read(3'd0, v);
    vectors++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %02h want 00", v);
    end
    wb_read(3'd2, v);
    vectors++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %02h want 00", v);
    end
  endtask

  task automatic test_mode0();
    logic [7:0] v, e;
    wb_write(3'd3, 8'h00);
    wb_write(3'd4, 8'h01);
    wb_write(3'd5, 8'h00);
    wb_write(3'd0, 8'h50);
    mon_start(1'b0, 1'b0, 1'b0);
    tx_q.push_back(8'hA5);
    rx_q.push_back(8'hA5);
    wb_write(3'd2, 8'hA5);
    wait_idle();
    mon_on = 1'b0;
    vectors++;
    if (ss_low !== 18) begin
      errors++;
      $display("FAIL mode0_ss_low: got %0d cycles want 18", ss_low);
    end
    vectors++;
    if (m_frames !== 1) begin
      errors++;
      $display("FAIL mode0_frames: got %0d want 1", m_frames);
    end
    wb_read(3'd2, v);
    e = rx_q.pop_front();
    vectors++;
    if (v !== e) begin
      errors++;
      $display("FAIL mode0_rx: got %02h want %02h", v, e);
    end
    wb_read(3'd1, v);
    vectors++;
    if (v !== 8'h85) begin
      errors++;
      $display("FAIL mode0_stat: got %02h want 85", v);
    end
  endtask

  task automatic test_mode3_lsbf();
    logic [7:0] v, e;
    wb_write(3'd1, 8'hE0);
    wb_write(3'd3, 8'h03);
    wb_write(3'd0, 8'h7C);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (sck !== 1'b1) begin
      errors++;
      $display("FAIL mode3_idle_sck: got %b want 1", sck);
    end
    mon_start(1'b1, 1'b1, 1'b1);
    tx_q.push_back(8'h01);
    rx_q.push_back(8'h01);
    wb_write(3'd2, 8'h01);
    tx_q.push_back(8'h80);
    rx_q.push_back(8'h80);
    wb_write(3'd2, 8'h80);
    wait_idle();
    mon_on = 1'b0;
    vectors++;
    if (iv_min !== 4 || iv_max !== 4) begin
      errors++;
      $display("FAIL mode3_halfper: min %0d max %0d want 4", iv_min, iv_max);
    end
    vectors++;
    if (ss_rise !== 1 || ss_low !== 136) begin
      errors++;
      $display("FAIL mode3_ss: rises %0d low %0d want 1/136", ss_rise, ss_low);
    end
    vectors++;
    if (m_frames !== 2) begin
      errors++;
      $display("FAIL mode3_frames: got %0d want 2", m_frames);
    end
    for (int i = 0; i < 2; i++) begin
      wb_read(3'd2, v);
      e = rx_q.pop_front();
      vectors++;
      if (v !== e) begin
        errors++;
        $display("FAIL mode3_rx: got %02h want %02h", v, e);
      end
    end
  endtask

  task automatic test_fifo();
    logic [7:0] v, e;
    wb_write(3'd0, 8'h00);
    wb_write(3'd1, 8'hE0);
    wb_write(3'd4, 8'h00);
    wb_write(3'd3, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'h10 + 8'(i));
      rx_q.push_back(8'h10 + 8'(i));
      wb_write(3'd2, 8'h10 + 8'(i));
    end
    wb_read(3'd1, v);
    vectors++;
    if (v !== 8'h09) begin
      errors++;
      $display("FAIL fifo_full: stat %02h want 09", v);
    end
    wb_write(3'd2, 8'hEE);
    wb_read(3'd1, v);
    vectors++;
    if (v !== 8'h49) begin
      errors++;
      $display("FAIL fifo_wcol: stat %02h want 49", v);
    end
    mon_start(1'b0, 1'b0, 1'b0);
    wb_write(3'd0, 8'h40);
    wait_idle();
    wb_read(3'd1, v);
    vectors++;
    if (v !== 8'hC6) begin
      errors++;
      $display("FAIL fifo_rxfull: stat %02h want C6", v);
    end
    tx_q.push_back(8'h99);
    wb_write(3'd2, 8'h99);
    wait_idle();
    mon_on = 1'b0;
    wb_read(3'd1, v);
    vectors++;
    if (v !== 8'hE6) begin
      errors++;
      $display("FAIL fifo_rovf: stat %02h want E6", v);
    end
    vectors++;
    if (m_frames !== 9) begin
      errors++;
      $display("FAIL fifo_frames: got %0d want 9", m_frames);
    end
    while (rx_q.size() > 0) begin
      wb_read(3'd2, v);
      e = rx_q.pop_front();
      vectors++;
      if (v !== e) begin
        errors++;
        $display("FAIL fifo_rx: got %02h want %02h", v, e);
      end
    end
    wb_read(3'd2, v);
    vectors++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL fifo_empty_read: got %02h want 00", v);
    end
    wb_read(3'd1, v);
    vectors++;
    if (v !== 8'hE5) begin
      errors++;
      $display("FAIL fifo_drained: stat %02h want E5", v);
    end
  endtask

  task automatic test_icnt();
    logic [7:0] v, e;
    wb_write(3'd1, 8'hE0);
    wb_write(3'd5, 8'h03);
    wb_write(3'd0, 8'hC0);
    vectors++;
    if (inta !== 1'b0) begin
      errors++;
      $display("FAIL icnt_pre: inta=%b want 0", inta);
    end
    mon_start(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back(8'hC3 ^ 8'(i * 37));
      rx_q.push_back(8'hC3 ^ 8'(i * 37));
      wb_write(3'd2, 8'hC3 ^ 8'(i * 37));
    end
    wait_idle();
    mon_on = 1'b0;
    vectors++;
    if (inta_frames !== 4 || inta !== 1'b1) begin
      errors++;
      $display("FAIL icnt_rise: rose after frame %0d inta=%b want 4/1",
               inta_frames, inta);
    end
    while (rx_q.size() > 0) begin
      wb_read(3'd2, v);
      e = rx_q.pop_front();
      vectors++;
      if (v !== e) begin
        errors++;
        $display("FAIL icnt_rx: got %02h want %02h", v, e);
      end
    end
    wb_write(3'd1, 8'h80);
    vectors++;
    if (inta !== 1'b0) begin
      errors++;
      $display("FAIL icnt_clear: inta=%b want 0", inta);
    end
    wb_write(3'd5, 8'h00);
  endtask

  task automatic test_abort();
    logic [7:0] v;
    int n;
    wb_write(3'd1, 8'hE0);
    wb_write(3'd3, 8'h01);
    wb_write(3'd4, 8'h01);
    wb_write(3'd0, 8'h50);
    mon_start(1'b0, 1'b0, 1'b0);
    wb_write(3'd2, 8'h5A);
    wb_write(3'd2, 8'h66);
    n = 0;
    while (m_edges < 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #3;
    vectors++;
    if (m_edges < 3) begin
      errors++;
      $display("FAIL abort_edges: saw %0d sck edges want 3", m_edges);
    end
    mon_on = 1'b0;
    wb_write(3'd0, 8'h10);
    vectors++;
    if (ss !== 8'hFF || sck !== 1'b0) begin
      errors++;
      $display("FAIL abort_pins: ss=%02h sck=%b want FF/0", ss, sck);
    end
    wb_read(3'd1, v);
    vectors++;
    if (v !== 8'h05) begin
      errors++;
      $display("FAIL abort_stat: got %02h want 05", v);
    end
    wb_read(3'd2, v);
    vectors++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL abort_rx: got %02h want 00", v);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] v, e;
`ifdef SPI_LOOPBACK_EN
    wb_write(3'd3, 8'h00);
    wb_write(3'd4, 8'hFF);
    wb_write(3'd0, 8'h42);
    miso_loop = 1'b0;
    mon_start(1'b0, 1'b0, 1'b0);
    tx_q.push_back(8'h3C);
    rx_q.push_back(8'h3C);
    wb_write(3'd2, 8'h3C);
    wait_idle();
    mon_on = 1'b0;
    vectors++;
    if (ss_low !== 0 || ss !== 8'hFF) begin
      errors++;
      $display("FAIL loop_ss: low %0d ss=%02h want 0/FF", ss_low, ss);
    end
    wb_read(3'd2, v);
    e = rx_q.pop_front();
    vectors++;
    if (v !== e) begin
      errors++;
      $display("FAIL loop_rx: got %02h want %02h", v, e);
    end
    wb_read(3'd0, v);
    vectors++;
    if (v !== 8'h42) begin
      errors++;
      $display("FAIL loop_ctrl: got %02h want 42", v);
    end
    miso_loop = 1'b1;
`else
    wb_write(3'd0, 8'h02);
    wb_read(3'd0, v);
    e = 8'h00;
    vectors++;
    if (v !== e) begin
      errors++;
      $display("FAIL loop_ctrl: got %02h want %02h", v, e);
    end
`endif
    wb_write(3'd0, 8'h00);
  endtask

  task automatic test_async_reset();
    wb_write(3'd3, 8'h03);
    wb_write(3'd4, 8'h01);
    wb_write(3'd0, 8'h50);
    wb_write(3'd2, 8'hF0);
    repeat (24) @(posedge clk);
    @(negedge clk);
    #1;
    rst_i = 1'b0;
    #1;
    vectors++;
    if (ss !== 8'hFF || sck !== 1'b0 || ack !== 1'b0 ||
        mosi !== 1'b0 || dat_o !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: ss=%02h sck=%b ack=%b mosi=%b dat=%02h",
               ss, sck, ack, mosi, dat_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    begin
      logic [7:0] v;
      wb_read(3'd1, v);
      vectors++;
      if (v !== 8'h05) begin
        errors++;
        $display("FAIL async_reset_stat: got %02h want 05", v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3_lsbf();
    test_fifo();
    test_icnt();
    test_abort();
    test_loopback();
    test_async_reset();
    vectors++;
    if (tx_q.size() != 0) begin
      errors++;
      $display("FAIL tx_scoreboard: %0d frames never seen", tx_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_fifo_wb.md
Name: spi_master_fifo_wb

Overview:
- 8-bit WISHBONE-slave SPI master. Successor to the 4-entry single-mode simple_spi controller.
- Adds parametrised TX/RX FIFO depth, slave-select width and divider width, plus LSB-first, automatic slave-select framing and a programmable frame-count interrupt.
- Sits between the WB interconnect and off-chip SPI slaves.

Parameters:
- SS_WIDTH, 8, number of active-low slave-select lines.
- FIFO_DEPTH, 8, entries per TX and RX FIFO; power of 2, range 2..64.
- DIV_W, 8, clock divider width; DIV register holds the low 8 bits, DIVH the upper DIV_W-8 bits (DIVH absent when DIV_W=8).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- cyc_i  in  1  WB cycle.
- stb_i  in  1  WB strobe.
- adr_i  in  3  WB register address.
- we_i  in  1  WB write enable.
- dat_i  in  8  WB write data.
- dat_o  out  8  WB read data, registered.
- ack_o  out  1  WB acknowledge.
- inta_o  out  1  interrupt, level.
- sck_o  out  1  SPI clock.
- ss_o  out  SS_WIDTH  slave selects, active low.
- mosi_o  out  1  master out.
- miso_i  in  1  master in.

Behaviour:
- Reset (rst_i low, async): ack_o=0, dat_o=0, inta_o=0, sck_o=0, ss_o=all 1, mosi_o=0. All registers 0, FIFOs empty, FSM IDLE.
- WB access:
  - ack_o rises the cycle after cyc_i&stb_i&!ack_o and lasts exactly one cycle.
  - Register writes and FIFO push/pop take effect on the acked cycle; dat_o is valid with ack_o.
- Register map:
  - 0 CTRL: [7]IE [6]EN [5]LSBF [4]ASS [3]CPOL [2]CPHA [1]LOOP [0]rsvd.
  - 1 STAT:
    - [7]IF, [6]WCOL, [5]ROVF: write-1-to-clear.
    - Read-only: [4]BUSY, [3]TXFULL, [2]TXEMPTY, [1]RXFULL, [0]RXEMPTY.
  - 2 DATA: write pushes TX FIFO; read pops RX FIFO. Read when empty returns 0x00 with no pointer change.
  - 3 DIV: low divider byte. SCK half-period = DIV+1 clk cycles (DIV=0 gives sck = clk/2).
  - 4 SS: manual select mask; bit n=1 drives ss_o[n] low.
  - 5 ICNT: IF sets when ICNT+1 frames complete since the last IF clear.
  - 6 DIVH: upper divider bits.
  - 7 reads 0.
- FIFO rules:
  - Push to full TX FIFO: data dropped, WCOL=1.
  - Frame completes with RX FIFO full: received byte dropped, ROVF=1; TX continues.
  - Pointers wrap modulo FIFO_DEPTH; the full/empty distinction uses one extra pointer bit.
- FSM:
  - IDLE: when EN=1 and TX not empty, pop TX into the shift register.
    - If ASS=1, go to LEAD.
    - If ASS=0, go to SHIFT.
  - LEAD: assert the selected ss_o lines; hold one half-period; go to SHIFT.
  - SHIFT: 16 half-periods per 8-bit frame.
    - sck toggles at each half-period end.
    - CPHA=0: data out before the first edge, sample on odd edges.
    - CPHA=1: shift out on the first edge, sample on the second.
    - Bit order is MSB-first unless LSBF=1.
    - At frame end, push the RX byte and increment the frame counter.
    - If TX not empty, pop and stay in SHIFT with no gap between frames.
    - Otherwise, if ASS=1 go to TRAIL; if ASS=0 go to IDLE.
  - TRAIL: hold one half-period with SS still asserted, then deassert SS; go to IDLE.
- Idle levels: sck_o=CPOL and mosi_o holds its last bit. Changing CPOL/CPHA/LSBF/DIV while BUSY is undefined for the current frame; software must not do it.
- ss_o: ~SS when ASS=0. When ASS=1, ~SS during LEAD/SHIFT/TRAIL and all 1 otherwise.
- BUSY=1 in any state other than IDLE.
- inta_o = IF & IE.
- Writing EN 1→0 at any time:
  - Abort immediately to IDLE.
  - sck_o=CPOL; ss_o all 1 if ASS.
  - Flush both FIFOs; clear frame counter.
  - Status flags are kept.
- Simultaneous WB push and FSM pop on the same cycle are both honoured; counts stay consistent.

Optional Feature:
- SPI_LOOPBACK_EN defined:
  - CTRL[1] LOOP is implemented.
  - LOOP=1 routes the internal mosi to the sampler instead of miso_i.
  - mosi_o/sck_o still toggle; ss_o is forced all 1.
- Not defined: CTRL[1] reads 0, writes are ignored, and miso_i is always sampled.

Test Plan:
- Reset: assert rst_i low mid-transfer with no clk edge → ss_o=0xFF, sck_o=0, ack_o=0 immediately; STAT reads 0x05 after release.
- Mode 0, DIV=0, ASS=1, SS=0x01; push 0xA5 with miso_i looping mosi_o → ss_o[0] low for 18 half-periods; mosi_o bit order 1,0,1,0,0,1,0,1; RX returns 0xA5; IF=1.
- Mode 3, LSBF=1, DIV=3; push 0x01,0x80 → sck_o idles high, half-period 4 clk; mosi_o sequence LSB-first; two RX bytes; no SS gap between frames.
- FIFO_DEPTH=8, EN=0: push 9 bytes → TXFULL after 8, WCOL=1; enable → 8 frames; with RX unread, the 9th frame sets ROVF=1.
- ICNT=3, IE=1: push 4 bytes → inta_o rises only after frame 4; writing STAT=0x80 clears inta_o.
- Clear EN after 3 sck edges → FSM IDLE next cycle, both FIFOs empty, BUSY=0; with SPI_LOOPBACK_EN, LOOP=1 and miso_i=0 → RX equals TX byte.
